// File: rtl/mux5bit_demux_1to4_buf.sv
// rtl/mux5bit_demux_1to4_buf.sv - 1:4 demux of a tagged word stream into four per-channel FIFOs
// Optional DEMUX_STATS_EN adds per-channel accept counters and a sticky DropErr flag.
module mux5bit_demux_1to4_buf #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               InValid,
  output logic               InReady,
  input  logic [WIDTH-1:0]   InData,
  input  logic [1:0]         InSel,
  output logic [3:0]         OutValid,
  input  logic [3:0]         OutReady,
  output logic [4*WIDTH-1:0] OutData,
  output logic [3:0]         Full
`ifdef DEMUX_STATS_EN
  ,
  output logic [4*8-1:0]     AcceptCount,
  output logic               DropErr
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q    [4][DEPTH];
  logic [AW-1:0]    wr_ptr_q [4];
  logic [AW-1:0]    wr_ptr_d [4];
  logic [AW-1:0]    rd_ptr_q [4];
  logic [AW-1:0]    rd_ptr_d [4];
  logic [CW-1:0]    cnt_q    [4];
  logic [CW-1:0]    cnt_d    [4];
  logic [3:0]       push;
  logic [3:0]       pop;
  logic             accept;

  for (genvar k = 0; k < 4; k++) begin : g_ch
    assign OutValid[k] = (cnt_q[k] != '0);
    assign Full[k]     = (cnt_q[k] == CW'(DEPTH));
    // Gated so OutData reads zero after reset even though storage is not cleared.
    assign OutData[k*WIDTH +: WIDTH] = OutValid[k] ? mem_q[k][rd_ptr_q[k]] : '0;
  end

  assign pop     = OutValid & OutReady;
  assign InReady = !Full[InSel] || pop[InSel];
  assign accept  = InValid && InReady;

  always_comb begin
    push = '0;
    if (accept) push[InSel] = 1'b1;
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      wr_ptr_d[k] = wr_ptr_q[k];
      rd_ptr_d[k] = rd_ptr_q[k];
      cnt_d[k]    = cnt_q[k];
      if (push[k]) wr_ptr_d[k] = wr_ptr_q[k] + AW'(1);
      if (pop[k])  rd_ptr_d[k] = rd_ptr_q[k] + AW'(1);
      case ({push[k], pop[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + CW'(1);
        2'b01:   cnt_d[k] = cnt_q[k] - CW'(1);
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int k = 0; k < 4; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        cnt_q[k]    <= cnt_d[k];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (accept) mem_q[InSel][wr_ptr_q[InSel]] <= InData;
  end

`ifdef DEMUX_STATS_EN
  logic [7:0] acc_cnt_q [4];
  logic [7:0] acc_cnt_d [4];
  logic       stall_q, stall_d;
  logic [1:0] sel_q, sel_d;
  logic       drop_q, drop_d;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      acc_cnt_d[k] = acc_cnt_q[k];
      if (push[k] && (acc_cnt_q[k] != 8'hFF)) acc_cnt_d[k] = acc_cnt_q[k] + 8'd1;
    end
    stall_d = InValid && !InReady;
    sel_d   = InSel;
    // A stalled source must hold its select; any change is a dropped/altered word.
    drop_d  = drop_q || (stall_q && InValid && (InSel != sel_q));
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int k = 0; k < 4; k++) acc_cnt_q[k] <= '0;
      stall_q <= 1'b0;
      sel_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) acc_cnt_q[k] <= acc_cnt_d[k];
      stall_q <= stall_d;
      sel_q   <= sel_d;
      drop_q  <= drop_d;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_stat
    assign AcceptCount[k*8 +: 8] = acc_cnt_q[k];
  end
  assign DropErr = drop_q;
`endif

endmodule

// File: tb/tb_mux5bit_demux_1to4_buf.sv
// tb/tb_mux5bit_demux_1to4_buf.sv - directed table, reset and random queue-model checks for the demux FIFO
module tb_mux5bit_demux_1to4_buf;
  localparam int W = 5;
  localparam int D = 2;

  logic           Clk = 1'b0;
  logic           Rst_n;
  logic           InValid;
  logic           InReady;
  logic [W-1:0]   InData;
  logic [1:0]     InSel;
  logic [3:0]     OutValid;
  logic [3:0]     OutReady;
  logic [4*W-1:0] OutData;
  logic [3:0]     Full;
`ifdef DEMUX_STATS_EN
  logic [31:0]    AcceptCount;
  logic           DropErr;
`endif

  mux5bit_demux_1to4_buf #(.WIDTH(W), .DEPTH(D)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(InReady),
    .InData(InData), .InSel(InSel), .OutValid(OutValid), .OutReady(OutReady),
    .OutData(OutData), .Full(Full)
`ifdef DEMUX_STATS_EN
    , .AcceptCount(AcceptCount), .DropErr(DropErr)
`endif
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic           v;
    logic [1:0]     s;
    logic [W-1:0]   d;
    logic [3:0]     r;
    logic           ir;
    logic [3:0]     ov;
    logic [3:0]     f;
    logic [4*W-1:0] od;
  } vec_t;

  vec_t tbl[18];

  logic [W-1:0] mq[4][$];

  task automatic model_clear();
    for (int k = 0; k < 4; k++) mq[k].delete();
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d, input logic [3:0] r);
    InValid = v; InSel = s; InData = d; OutReady = r;
  endtask

  task automatic do_reset();
    drive(1'b0, 2'd0, '0, 4'h0);
    Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #3 Rst_n = 1'b1;
    @(posedge Clk); #1;
    model_clear();
  endtask

  initial begin
    logic [4*W-1:0] exp_od;
    logic [3:0]     exp_ov, exp_f, pops;
    logic           exp_ir, hold;
    int             sz;

    tbl[0]  = '{1'b1, 2'd0, 5'h11, 4'hF, 1'b1, 4'h0, 4'h0, 20'h0};
    tbl[1]  = '{1'b0, 2'd0, 5'h00, 4'hF, 1'b1, 4'h1, 4'h0, 20'h00011};
    tbl[2]  = '{1'b0, 2'd0, 5'h00, 4'hF, 1'b1, 4'h0, 4'h0, 20'h0};
    tbl[3]  = '{1'b1, 2'd1, 5'h01, 4'hD, 1'b1, 4'h0, 4'h0, 20'h0};
    tbl[4]  = '{1'b1, 2'd1, 5'h02, 4'hD, 1'b1, 4'h2, 4'h0, 20'h00020};
    tbl[5]  = '{1'b1, 2'd1, 5'h03, 4'hD, 1'b0, 4'h2, 4'h2, 20'h00020};
    tbl[6]  = '{1'b1, 2'd2, 5'h1F, 4'hD, 1'b1, 4'h2, 4'h2, 20'h00020};
    tbl[7]  = '{1'b1, 2'd1, 5'h03, 4'hD, 1'b0, 4'h6, 4'h2, 20'h07C20};
    tbl[8]  = '{1'b1, 2'd1, 5'h03, 4'hF, 1'b1, 4'h2, 4'h2, 20'h00020};
    tbl[9]  = '{1'b0, 2'd0, 5'h00, 4'hF, 1'b1, 4'h2, 4'h2, 20'h00040};
    tbl[10] = '{1'b0, 2'd0, 5'h00, 4'hF, 1'b1, 4'h2, 4'h0, 20'h00060};
    tbl[11] = '{1'b0, 2'd0, 5'h00, 4'hF, 1'b1, 4'h0, 4'h0, 20'h0};
    tbl[12] = '{1'b1, 2'd0, 5'h00, 4'hF, 1'b1, 4'h0, 4'h0, 20'h0};
    tbl[13] = '{1'b1, 2'd1, 5'h01, 4'hF, 1'b1, 4'h1, 4'h0, 20'h0};
    tbl[14] = '{1'b1, 2'd2, 5'h02, 4'hF, 1'b1, 4'h2, 4'h0, 20'h00020};
    tbl[15] = '{1'b1, 2'd3, 5'h03, 4'hF, 1'b1, 4'h4, 4'h0, 20'h00800};
    tbl[16] = '{1'b0, 2'd0, 5'h00, 4'hF, 1'b1, 4'h8, 4'h0, 20'h18000};
    tbl[17] = '{1'b0, 2'd0, 5'h00, 4'hF, 1'b1, 4'h0, 4'h0, 20'h0};

    drive(1'b0, 2'd0, '0, 4'h0);
    Rst_n = 1'b0;
    @(negedge Clk);
    check("reset_outvalid", 32'(OutValid), 32'h0);
    check("reset_full", 32'(Full), 32'h0);
    check("reset_outdata", 32'(OutData), 32'h0);
    #3 Rst_n = 1'b1;
    @(posedge Clk); #1;
    check("post_reset_inready", 32'(InReady), 32'h1);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r);
      @(negedge Clk);
      check($sformatf("tbl%0d_inready", i), 32'(InReady), 32'(tbl[i].ir));
      check($sformatf("tbl%0d_outvalid", i), 32'(OutValid), 32'(tbl[i].ov));
      check($sformatf("tbl%0d_full", i), 32'(Full), 32'(tbl[i].f));
      check($sformatf("tbl%0d_outdata", i), 32'(OutData), 32'(tbl[i].od));
      @(posedge Clk); #1;
    end

    do_reset();
    drive(1'b1, 2'd0, 5'h05, 4'hE);
    @(posedge Clk); #1;
    drive(1'b1, 2'd0, 5'h06, 4'hE);
    @(posedge Clk); #1;
    InValid = 1'b0;
    check("prefill_outvalid", 32'(OutValid), 32'h1);
    check("prefill_full", 32'(Full), 32'h1);
    #2 Rst_n = 1'b0;
    #1;
    check("async_rst_outvalid", 32'(OutValid), 32'h0);
    check("async_rst_full", 32'(Full), 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    drive(1'b1, 2'd0, 5'h0A, 4'hF);
    @(posedge Clk); #1;
    InValid = 1'b0;
    check("after_rst_outvalid", 32'(OutValid), 32'h1);
    check("after_rst_first_word", 32'(OutData[W-1:0]), 32'h0A);
    @(posedge Clk); #1;
    check("after_rst_drained", 32'(OutValid), 32'h0);

    do_reset();
    hold = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!hold) begin
        InValid = ($urandom_range(0, 3) != 0);
        InSel   = 2'($urandom_range(0, 3));
        InData  = W'($urandom);
      end
      OutReady = 4'($urandom_range(0, 15));
      @(negedge Clk);
      for (int k = 0; k < 4; k++) begin
        sz = mq[k].size();
        exp_ov[k] = (sz != 0);
        exp_f[k]  = (sz == D);
        exp_od[k*W +: W] = (sz != 0) ? mq[k][0] : '0;
        pops[k] = (sz != 0) && OutReady[k];
      end
      exp_ir = (mq[InSel].size() < D) || pops[InSel];
      check($sformatf("rnd%0d_inready", i), 32'(InReady), 32'(exp_ir));
      check($sformatf("rnd%0d_outvalid", i), 32'(OutValid), 32'(exp_ov));
      check($sformatf("rnd%0d_full", i), 32'(Full), 32'(exp_f));
      check($sformatf("rnd%0d_outdata", i), 32'(OutData), 32'(exp_od));
      hold = InValid && !exp_ir;
      @(posedge Clk); #1;
      for (int k = 0; k < 4; k++) if (pops[k]) void'(mq[k].pop_front());
      if (InValid && exp_ir) mq[InSel].push_back(InData);
    end

`ifdef DEMUX_STATS_EN
    do_reset();
    check("stats_reset_count", AcceptCount, 32'h0);
    check("stats_reset_drop", 32'(DropErr), 32'h0);
    drive(1'b1, 2'd3, 5'h07, 4'hF);
    for (int i = 0; i < 300; i++) begin
      @(posedge Clk); #1;
    end
    InValid = 1'b0;
    @(negedge Clk);
    check("stats_sat_count", AcceptCount, {8'd255, 24'd0});
    drive(1'b1, 2'd0, 5'h01, 4'hE);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("stats_no_drop_while_held", 32'(DropErr), 32'h0);
    InSel = 2'd1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    @(negedge Clk);
    check("stats_drop_set", 32'(DropErr), 32'h1);
    repeat (3) @(posedge Clk);
    #1 check("stats_drop_sticky", 32'(DropErr), 32'h1);
    do_reset();
    check("stats_drop_cleared", 32'(DropErr), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
